// File: rtl/bias_relu_pkg.sv
// bias_relu_pkg: shared state encoding, register map and Q16.16 limits for bias_relu_wb.
package bias_relu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD_IN, S_WT_IN, S_RD_B, S_WT_B, S_WR} state_t;
  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_BIAS = 4'd2;
  localparam logic [3:0] REG_IN   = 4'd3;
  localparam logic [3:0] REG_OUT  = 4'd4;
  localparam logic [3:0] REG_N    = 4'd5;
  localparam logic [31:0] Q16_MAX = 32'h7FFFFFFF;
endpackage

// File: rtl/bias_relu.sv
// bias_relu: saturating Q16.16 add followed by ReLU; combinational.
module bias_relu
  import bias_relu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y,
  output logic        o_nonzero
);
  logic [32:0] w_sum;
  assign w_sum = {i_a[31], i_a} + {i_b[31], i_b};
  // positive overflow saturates, any non-positive sum clamps to zero
  assign o_y = (!w_sum[32] && w_sum[31]) ? Q16_MAX :
               (w_sum[32] || w_sum == 33'd0) ? 32'd0 : w_sum[31:0];
  assign o_nonzero = |o_y;
endmodule

// File: rtl/bias_relu_wb.sv
// bias_relu_wb: Avalon-MM accelerator computing out[i] = ReLU(in[i] + bias[i]) with saturation.
module bias_relu_wb
  import bias_relu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);
  state_t      r_state, w_nxt;
  logic [31:0] r_bias_base, r_in_base, r_out_base, r_n;
  logic [31:0] r_run_bias, r_run_in, r_run_out, r_left, r_off, r_nz, r_in_val;
  logic [31:0] w_off, w_addr, w_y;
  logic        w_busy, w_start, w_acc, w_cap_in, w_cap_b, w_nz;

  assign w_busy   = r_state != S_IDLE;
  assign w_start  = slave_write && slave_address == REG_CTRL && !w_busy;
  assign w_acc    = (master_read || master_write) && !master_waitrequest;
  // read data may return in the acceptance cycle itself, so capture from RD_* too
  assign w_cap_in = master_readdatavalid && ((r_state == S_RD_IN && w_acc) || r_state == S_WT_IN);
  assign w_cap_b  = master_readdatavalid && ((r_state == S_RD_B && w_acc) || r_state == S_WT_B);

  assign slave_waitrequest = slave_read && slave_address == REG_CTRL && w_busy;
  assign slave_readdata = !slave_read                  ? 32'd0 :
                          slave_address == REG_CTRL ? r_nz :
                          slave_address == REG_BIAS ? r_bias_base :
                          slave_address == REG_IN   ? r_in_base :
                          slave_address == REG_OUT  ? r_out_base :
                          slave_address == REG_N    ? r_n : 32'd0;

  bias_relu u_act (
    .i_a       (r_in_val),
    .i_b       (master_readdata),
    .o_y       (w_y),
    .o_nonzero (w_nz)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && r_n != 32'd0) w_nxt = S_RD_IN;
      S_RD_IN: if (w_acc) w_nxt = master_readdatavalid ? S_RD_B : S_WT_IN;
      S_WT_IN: if (master_readdatavalid) w_nxt = S_RD_B;
      S_RD_B:  if (w_acc) w_nxt = master_readdatavalid ? S_WR : S_WT_B;
      S_WT_B:  if (master_readdatavalid) w_nxt = S_WR;
      S_WR:    if (w_acc) w_nxt = (r_left == 32'd1) ? S_IDLE : S_RD_IN;
      default: w_nxt = S_IDLE;
    endcase
    w_off  = w_start ? 32'd0 : (r_state == S_WR && w_acc) ? r_off + 32'd4 : r_off;
    // the first fetch is issued while the run copies are still being latched
    w_addr = (w_nxt == S_RD_IN) ? ((r_state == S_IDLE) ? r_in_base : r_run_in) + w_off :
             (w_nxt == S_RD_B)  ? r_run_bias + w_off :
             (w_nxt == S_WR)    ? r_run_out + w_off : master_address;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_bias_base      <= '0;
      r_in_base        <= '0;
      r_out_base       <= '0;
      r_n              <= '0;
      r_run_bias       <= '0;
      r_run_in         <= '0;
      r_run_out        <= '0;
      r_left           <= '0;
      r_off            <= '0;
      r_nz             <= '0;
      r_in_val         <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
    end else begin
      r_state        <= w_nxt;
      r_off          <= w_off;
      master_read    <= w_nxt == S_RD_IN || w_nxt == S_RD_B;
      master_write   <= w_nxt == S_WR;
      master_address <= w_addr;
      if (slave_write && slave_address == REG_BIAS) r_bias_base <= slave_writedata;
      if (slave_write && slave_address == REG_IN)   r_in_base   <= slave_writedata;
      if (slave_write && slave_address == REG_OUT)  r_out_base  <= slave_writedata;
      if (slave_write && slave_address == REG_N)    r_n         <= slave_writedata;
      if (w_start) begin
        r_run_bias <= r_bias_base;
        r_run_in   <= r_in_base;
        r_run_out  <= r_out_base;
        r_left     <= r_n;
        r_nz       <= '0;
      end else if (r_state == S_WR && w_acc) begin
        r_left <= r_left - 32'd1;
      end
      if (w_cap_in) r_in_val <= master_readdata;
      if (w_cap_b) begin
        master_writedata <= w_y;
        r_nz             <= r_nz + {31'd0, w_nz};
      end
    end
  end
endmodule

// File: tb/tb_bias_relu_wb.sv
// tb_bias_relu_wb: directed bench with a memory/fabric model, bus-stability monitor and write log.
module tb_bias_relu_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  int n_chk = 0;
  int n_fail = 0;
  int wait_n = 0;
  int lat = 1;
  int wcnt, rv_cnt;
  logic [31:0] rv_data;
  logic [31:0] img [0:255];
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  int wr_count = 0;
  int ovl = 0;
  int stab_err = 0;
  int n_req = 0;
  logic p_stall = 1'b0;
  logic [65:0] p_sig;

  localparam logic [31:0] IN_B = 32'h100, BI_B = 32'h200, OUT_B = 32'h300, OUT2_B = 32'h380;
  logic [31:0] in_a [4] = '{32'h00010000, 32'hFFFE0000, 32'h00008000, 32'h0};
  logic [31:0] bi_a [4] = '{32'h00010000, 32'h00010000, 32'hFFFF8000, 32'h0};
  logic [31:0] ex_a [4] = '{32'h00020000, 32'h0, 32'h0, 32'h0};
  logic [31:0] in_s [4] = '{32'h7FFF0000, 32'h80000000, 32'h0, 32'h0};
  logic [31:0] bi_s [4] = '{32'h00020000, 32'h80000000, 32'h0, 32'h0};
  logic [31:0] ex_s [4] = '{32'h7FFFFFFF, 32'h0, 32'h0, 32'h0};

  bias_relu_wb dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  assign master_waitrequest   = (master_read || master_write) && (wcnt < wait_n);
  assign master_readdatavalid = rv_cnt == 1;
  assign master_readdata      = rv_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= 0;
      rv_cnt <= 0;
    end else begin
      if (rv_cnt != 0) rv_cnt <= rv_cnt - 1;
      if (master_read || master_write) begin
        if (master_waitrequest) wcnt <= wcnt + 1;
        else begin
          wcnt <= 0;
          if (master_read) begin
            if (rv_cnt > 1) ovl <= ovl + 1;
            rv_cnt  <= lat;
            rv_data <= img[master_address[9:2]];
          end else begin
            if (wr_count < 64) begin
              log_addr[wr_count] <= master_address;
              log_data[wr_count] <= master_writedata;
            end
            wr_count <= wr_count + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) p_stall <= 1'b0;
    else begin
      if (p_stall && {master_read, master_write, master_address, master_writedata} != p_sig)
        stab_err <= stab_err + 1;
      p_stall <= (master_read || master_write) && master_waitrequest;
      p_sig   <= {master_read, master_write, master_address, master_writedata};
      if (master_read || master_write) n_req <= n_req + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_write = 1'b1; slave_address = a; slave_writedata = d;
    @(posedge clk);
    #1 slave_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d, output int k);
    k = 0;
    @(negedge clk);
    slave_read = 1'b1; slave_address = a;
    #1;
    while (slave_waitrequest && k < 2000) begin
      @(negedge clk);
      #1 k++;
    end
    d = slave_readdata;
    chk("rd_bound", 32'(k < 2000), 32'd1);
    @(posedge clk);
    #1 slave_read = 1'b0;
  endtask

  task automatic load(input logic [31:0] vi [4], input logic [31:0] vb [4]);
    for (int i = 0; i < 4; i++) begin
      img[IN_B[9:2] + 8'(i)] = vi[i];
      img[BI_B[9:2] + 8'(i)] = vb[i];
    end
  endtask

  task automatic prog(input logic [31:0] ob, input logic [31:0] n);
    wr(4'd2, BI_B); wr(4'd3, IN_B); wr(4'd4, ob); wr(4'd5, n);
  endtask

  task automatic chk_log(input string tag, input int base, input int n, input logic [31:0] ob,
                         input logic [31:0] ex [4]);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_addr[base + i], ob + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), log_data[base + i], ex[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    int k, base, q;
    rst_n = 1'b0; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    for (int i = 0; i < 256; i++) img[i] = 32'hDEADBEEF;
    #12;
    chk("rst_mread", 32'(master_read), 32'd0);
    chk("rst_mwrite", 32'(master_write), 32'd0);
    chk("rst_maddr", master_address, 32'd0);
    chk("rst_mwdata", master_writedata, 32'd0);
    chk("rst_swait", 32'(slave_waitrequest), 32'd0);
    #10 rst_n = 1'b1;
    rd(4'd0, d, k); chk("rst_reg0", d, 32'd0);
    for (int r = 2; r <= 5; r++) begin
      rd(4'(r), d, k); chk($sformatf("rst_reg%0d", r), d, 32'd0);
    end
    rd(4'd7, d, k); chk("rst_reg7", d, 32'd0);

    load(in_a, bi_a); prog(OUT_B, 32'd4);
    base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("n4_cycles", 32'(k), 32'd20);
    chk("n4_nz", d, 32'd1);
    chk("n4_wcount", 32'(wr_count - base), 32'd4);
    chk_log("n4", base, 4, OUT_B, ex_a);

    load(in_s, bi_s); prog(OUT_B, 32'd2);
    base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("sat_cycles", 32'(k), 32'd10);
    chk("sat_nz", d, 32'd1);
    chk("sat_wcount", 32'(wr_count - base), 32'd2);
    chk_log("sat", base, 2, OUT_B, ex_s);

    prog(OUT_B, 32'd0);
    q = n_req; base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("n0_wait", 32'(k), 32'd0);
    chk("n0_nz", d, 32'd0);
    repeat (3) @(negedge clk);
    chk("n0_noreq", 32'(n_req - q), 32'd0);
    chk("n0_wcount", 32'(wr_count - base), 32'd0);

    wait_n = 2; lat = 2;
    load(in_a, bi_a); prog(OUT_B, 32'd4);
    base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("slow_nz", d, 32'd1);
    chk("slow_wcount", 32'(wr_count - base), 32'd4);
    chk_log("slow", base, 4, OUT_B, ex_a);
    chk("slow_stable", 32'(stab_err), 32'd0);
    chk("slow_outstanding", 32'(ovl), 32'd0);
    wait_n = 0; lat = 1;

    prog(OUT_B, 32'd4);
    base = wr_count;
    wr(4'd0, 32'd0);
    k = 0;
    while (wr_count - base < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_bound", 32'(k < 500), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_mread", 32'(master_read), 32'd0);
    chk("rstmid_mwrite", 32'(master_write), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_wcount", 32'(wr_count - base), 32'd2);
    chk_log("rstmid", base, 2, OUT_B, ex_a);
    rd(4'd5, d, k); chk("rstmid_reg5", d, 32'd0);
    prog(OUT_B, 32'd4);
    base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("rerun_nz", d, 32'd1);
    chk("rerun_wcount", 32'(wr_count - base), 32'd4);
    chk_log("rerun", base, 4, OUT_B, ex_a);

    base = wr_count;
    wr(4'd0, 32'd0);
    wr(4'd5, 32'd2);
    wr(4'd4, OUT2_B);
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("mid_nz", d, 32'd1);
    chk("mid_wcount", 32'(wr_count - base), 32'd4);
    chk_log("mid", base, 4, OUT_B, ex_a);
    repeat (3) @(negedge clk);
    chk("mid_nostart", 32'(wr_count - base), 32'd4);
    rd(4'd5, d, k); chk("mid_reg5", d, 32'd2);
    rd(4'd4, d, k); chk("mid_reg4", d, OUT2_B);
    rd(4'd2, d, k); chk("mid_reg2", d, BI_B);
    base = wr_count;
    wr(4'd0, 32'd0);
    rd(4'd0, d, k);
    chk("next_nz", d, 32'd1);
    chk("next_wcount", 32'(wr_count - base), 32'd2);
    chk_log("next", base, 2, OUT2_B, ex_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bias_relu_wb.md
# bias_relu_wb

Avalon-MM accelerator that applies the activation step after the dot-product engine. It reads a pre-activation vector of Q16.16 sums (one per output neuron, as produced by repeated `dot` runs) and a bias vector from memory. For each element it computes ReLU(in + bias) with saturation and writes the result to an output vector. The CPU programs it through a slave register file; it fetches and writes back through a single master port on the shared memory fabric.

## Interface
Parameters:
- none; data width fixed at 32 bits (Q16.16 signed), word stride fixed at 4 bytes.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- slave_waitrequest  out  1  stalls CPU access
- slave_address  in  4  word index into register file
- slave_read  in  1  CPU read strobe
- slave_readdata  out  32  CPU read data
- slave_write  in  1  CPU write strobe
- slave_writedata  in  32  CPU write data
- master_waitrequest  in  1  fabric stall
- master_address  out  32  byte address
- master_read  out  1  read request
- master_readdata  in  32  read data
- master_readdatavalid  in  1  read data valid
- master_write  out  1  write request
- master_writedata  out  32  write data

## Operation
- Registers: 0 = start (write, any data) / result (read); 2 = bias base; 3 = input base; 4 = output base; 5 = N (element count). Registers 2–5 read back their stored values. Other indices read 0 and ignore writes.
- Start: a write to reg 0 while IDLE latches bases, N and clears `nz_count`. A write to reg 0 while busy is ignored. Writes to regs 2–5 while busy update the registers but do not affect the current run.
- Per element i, addresses are base + 4*i:
  - read in[i], then read bias[i];
  - sum = in + bias, 33-bit signed;
  - if sum > 0x7FFFFFFF the result is 0x7FFFFFFF; else if sum ≤ 0 the result is 0; else the result is sum[31:0];
  - write out[i];
  - nz_count increments when the result ≠ 0.
- Reading reg 0: slave_waitrequest is held high while busy. Once IDLE, it returns nz_count.
- States:
  - IDLE → RD_IN (start with N>0; N=0 completes without master traffic)
  - RD_IN → WT_IN on accept
  - WT_IN → RD_B on readdatavalid
  - RD_B → WT_B on accept
  - WT_B → WR on readdatavalid
  - WR → RD_IN on accept when i+1<N, else IDLE
- A request is "accepted" in a cycle where it is asserted and master_waitrequest is low. Only one read is outstanding at a time.
- Reset mid-operation: returns to IDLE immediately. A write already accepted stands; no further traffic is issued.

## Timing
- Reset values:
  - master_read, master_write = 0;
  - master_address, master_writedata = 0;
  - slave_readdata = 0, slave_waitrequest = 0;
  - all registers and nz_count = 0.
- slave_waitrequest = slave_read & (slave_address==0) & busy, combinational.
- slave_readdata is valid in the cycle slave_read is high and slave_waitrequest is low (zero wait states).
- master_address, master_read/write and master_writedata are registered outputs. They stay stable while master_waitrequest is high.
- master_read deasserts the cycle after acceptance. The block tolerates readdatavalid arriving in the acceptance cycle or any later cycle.
- Zero-wait fabric with readdatavalid one cycle after accept: 5 cycles per element; total 5N+1 from start write to IDLE.
- busy rises the cycle after the start write.

## Structure
- Package `bias_relu_pkg`:
  - state enum;
  - register index constants (REG_CTRL=0, REG_BIAS=2, REG_IN=3, REG_OUT=4, REG_N=5);
  - Q16_MAX = 32'h7FFFFFFF.
- Sub-module `bias_relu`: combinational saturating add plus ReLU, (a, b) → (y, nonzero). It is unit-testable on its own.
- Top level holds the register file, element counter, address generators and FSM.

## Test plan
- N=4:
  - in = {0x00010000, 0xFFFE0000, 0x00008000, 0}
  - bias = {0x00010000, 0x00010000, 0xFFFF8000, 0}
  - → out = {0x00020000, 0, 0, 0}; reg0 read returns 1.
- Saturation:
  - in 0x7FFF0000 + bias 0x00020000 → 0x7FFFFFFF;
  - in 0x80000000 + bias 0x80000000 → 0.
  - Both elements in one N=2 run; reg0 returns 1.
- N=0 → no master_read/master_write ever asserted; reg0 read returns 0 within 2 cycles.
- Fabric with 2-cycle waitrequest and readdatavalid 2 cycles after accept → same results as the N=4 test. Checker verifies address, data and strobes are stable during waitrequest, and never more than one read outstanding.
- rst_n pulsed low after the 2nd output write of an N=4 run:
  - master strobes drop asynchronously;
  - only out[0..1] are written;
  - a re-run after reprogramming is correct.
- Start write issued mid-run and reg5 changed mid-run → current run unaffected. Reg2–5 readback returns the new values; the next run uses them.
